// File: rtl/hidden_sum_acc_if.sv
// rtl/hidden_sum_acc_if.sv - beat-in / sum-out handshake bundle for the hidden-unit accumulator
interface hidden_sum_acc_if #(
    parameter int BITN     = 8,
    parameter int SUM_BITN = 12
);
    logic                start;
    logic [BITN-1:0]     bias;
    logic                in_valid;
    logic                in_ready;
    logic                v_bit;
    logic [BITN-1:0]     w;
    logic                sum_valid;
    logic                sum_ready;
    logic [SUM_BITN-1:0] sum;
    logic                sat_flag;
    logic                busy;

    modport master (
        output start, bias, in_valid, v_bit, w, sum_ready,
        input  in_ready, sum_valid, sum, sat_flag, busy
    );

    modport slave (
        input  start, bias, in_valid, v_bit, w, sum_ready,
        output in_ready, sum_valid, sum, sat_flag, busy
    );
endinterface

// File: rtl/hidden_sum_acc.sv
// rtl/hidden_sum_acc.sv - serial bias + sum(v_i*w_i) accumulator with saturated Q8.4 result
module hidden_sum_acc #(
    parameter int BITN     = 8,
    parameter int SUM_BITN = 12,
    parameter int N_IN     = 784,
    parameter int CNT_BITN = 10,
    parameter int ACC_BITN = 20
) (
    input  logic           clk,
    input  logic           rst,
    hidden_sum_acc_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_BITN-1:0]        LAST_CNT = CNT_BITN'(N_IN - 1);
    localparam logic signed [ACC_BITN-1:0] SUM_MAX  = ACC_BITN'((1 << (SUM_BITN - 1)) - 1);
    localparam logic signed [ACC_BITN-1:0] SUM_MIN  = ~SUM_MAX;

    state_t state;
    state_t state_next;

    logic signed [ACC_BITN-1:0] acc;
    logic signed [ACC_BITN-1:0] acc_next;
    logic signed [ACC_BITN-1:0] bias_ext;
    logic signed [ACC_BITN-1:0] w_ext;
    logic [CNT_BITN-1:0]        cnt;
    logic [SUM_BITN-1:0]        sum_q;
    logic                       sat_q;
    logic [SUM_BITN-1:0]        sat_sum;
    logic                       sat_hit;
    logic                       beat;
    logic                       last_beat;
    logic                       ready_c;
    logic                       valid_c;
    logic                       busy_c;

    // Q4.4 operands enter the Q.4 accumulator by sign extension only
    assign bias_ext  = {{(ACC_BITN - BITN){bus.bias[BITN-1]}}, bus.bias};
    assign w_ext     = {{(ACC_BITN - BITN){bus.w[BITN-1]}}, bus.w};
    assign acc_next  = acc + (bus.v_bit ? w_ext : '0);
    assign beat      = bus.in_valid && (state == ACCUM);
    assign last_beat = beat && (cnt == LAST_CNT);

    always_comb begin
        sat_sum = acc_next[SUM_BITN-1:0];
        sat_hit = 1'b0;
        if (acc_next > SUM_MAX) begin
            sat_sum = SUM_MAX[SUM_BITN-1:0];
            sat_hit = 1'b1;
        end else if (acc_next < SUM_MIN) begin
            sat_sum = SUM_MIN[SUM_BITN-1:0];
            sat_hit = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ready_c    = 1'b0;
        valid_c    = 1'b0;
        busy_c     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = ACCUM;
                end
            end
            ACCUM: begin
                ready_c = 1'b1;
                busy_c  = 1'b1;
                if (last_beat) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                valid_c = 1'b1;
                busy_c  = 1'b1;
                if (bus.sum_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // sum/sat_flag persist past HOLD until the next completion or reset
    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            cnt   <= '0;
            sum_q <= '0;
            sat_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc <= bias_ext;
                        cnt <= '0;
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        acc <= acc_next;
                        if (last_beat) begin
                            cnt   <= '0;
                            sum_q <= sat_sum;
                            sat_q <= sat_hit;
                        end else begin
                            cnt <= cnt + CNT_BITN'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = ready_c;
    assign bus.sum_valid = valid_c;
    assign bus.busy      = busy_c;
    assign bus.sum       = sum_q;
    assign bus.sat_flag  = sat_q;
endmodule

// File: tb/tb_hidden_sum_acc.sv
// tb/tb_hidden_sum_acc.sv - randomized directed bench for hidden_sum_acc with integer reference model
module tb_hidden_sum_acc;
    localparam int BITN     = 8;
    localparam int SUM_BITN = 12;
    localparam int N_IN     = 784;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    bit                v_arr [N_IN];
    logic [BITN-1:0]   w_arr [N_IN];

    hidden_sum_acc_if #(.BITN(BITN), .SUM_BITN(SUM_BITN)) bus ();

    hidden_sum_acc #(
        .BITN(BITN), .SUM_BITN(SUM_BITN), .N_IN(N_IN), .CNT_BITN(10), .ACC_BITN(20)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer sum of bias and selected weights, then clamp to Q8.4
    task automatic model(input logic [BITN-1:0] b, output logic [SUM_BITN-1:0] s, output logic f);
        int total;
        total = int'($signed(b));
        for (int i = 0; i < N_IN; i++) begin
            if (v_arr[i]) total += int'($signed(w_arr[i]));
        end
        f = 1'b0;
        if (total > 2047) begin
            total = 2047;
            f = 1'b1;
        end else if (total < -2048) begin
            total = -2048;
            f = 1'b1;
        end
        s = total[SUM_BITN-1:0];
    endtask

    task automatic do_run(input string tag, input logic [BITN-1:0] b, input bit gap,
                          input int hold, input bit poke);
        logic [SUM_BITN-1:0] es;
        logic                ef;
        int                  i;
        int                  guard;
        int                  t0;
        bit                  bad_ready;
        bit                  bad_early;
        bit                  bad_hold;
        model(b, es, ef);
        bad_ready = 0;
        bad_early = 0;
        bad_hold  = 0;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.bias     = b;
        bus.in_valid = 1'b0;
        t0 = cyc;
        @(negedge clk);
        bus.start = 1'b0;
        bus.bias  = BITN'($urandom);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
        i = 0;
        guard = 0;
        while (i < N_IN && guard < 20000) begin
            bus.in_valid = (gap && $urandom_range(1) == 0) ? 1'b0 : 1'b1;
            if (bus.in_valid) begin
                bus.v_bit = v_arr[i];
                bus.w     = w_arr[i];
            end else begin
                bus.v_bit = 1'($urandom);
                bus.w     = BITN'($urandom);
            end
            bus.start = poke && (guard == 50 || guard == 51);
            if (bus.in_ready !== 1'b1) bad_ready = 1;
            if (bus.sum_valid !== 1'b0) bad_early = 1;
            @(negedge clk);
            if (bus.in_valid) i++;
            guard++;
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        chk({tag, "_beats"}, 32'(i), 32'(N_IN));
        chk({tag, "_in_ready"}, 32'(bad_ready), 32'd0);
        chk({tag, "_no_early_valid"}, 32'(bad_early), 32'd0);
        chk({tag, "_sum_valid"}, 32'(bus.sum_valid), 32'd1);
        if (!gap) chk({tag, "_latency"}, 32'(cyc - t0), 32'(N_IN + 1));
        chk({tag, "_sum"}, 32'(bus.sum), 32'(es));
        chk({tag, "_sat"}, 32'(bus.sat_flag), 32'(ef));
        bus.sum_ready = 1'b0;
        for (int k = 0; k < hold; k++) begin
            bus.start = poke;
            @(negedge clk);
            if (bus.sum_valid !== 1'b1 || bus.sum !== es || bus.sat_flag !== ef ||
                bus.in_ready !== 1'b0 || bus.busy !== 1'b1) bad_hold = 1;
        end
        chk({tag, "_hold_stable"}, 32'(bad_hold), 32'd0);
        bus.sum_ready = 1'b1;
        bus.start     = poke;
        @(negedge clk);
        bus.sum_ready = 1'b0;
        bus.start     = 1'b0;
        chk({tag, "_valid_drop"}, 32'(bus.sum_valid), 32'd0);
        chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
        chk({tag, "_sum_kept"}, 32'(bus.sum), 32'(es));
    endtask

    initial begin
        logic [BITN-1:0] rb;
        bus.start     = 1'b0;
        bus.bias      = '0;
        bus.in_valid  = 1'b0;
        bus.v_bit     = 1'b0;
        bus.w         = '0;
        bus.sum_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_sum_valid", 32'(bus.sum_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_sum", 32'(bus.sum), 32'd0);
        chk("rst_sat", 32'(bus.sat_flag), 32'd0);

        for (int i = 0; i < N_IN; i++) begin
            v_arr[i] = 1'b0;
            w_arr[i] = BITN'($urandom);
        end
        do_run("vzero", 8'h10, 1'b0, 0, 1'b0);

        for (int i = 0; i < N_IN; i++) begin
            v_arr[i] = 1'b1;
            w_arr[i] = 8'h7F;
        end
        do_run("sat_pos", 8'h00, 1'b0, 10, 1'b0);
        for (int i = 0; i < N_IN; i++) w_arr[i] = 8'h80;
        do_run("sat_neg", 8'h00, 1'b1, 0, 1'b0);

        for (int i = 0; i < N_IN; i++) begin
            v_arr[i] = (i % 2 == 0);
            w_arr[i] = 8'h01;
        end
        do_run("alt", 8'hF0, 1'b0, 0, 1'b0);
        do_run("alt_gap", 8'hF0, 1'b1, 2, 1'b0);

        for (int i = 0; i < N_IN; i++) begin
            v_arr[i] = 1'($urandom);
            w_arr[i] = BITN'($urandom_range(0, 15)) - 8'd8;
        end
        rb = BITN'($urandom);
        do_run("rnd_poke", rb, 1'b0, 3, 1'b1);
        do_run("rnd_gap", rb, 1'b1, 0, 1'b0);

        @(negedge clk);
        bus.start = 1'b1;
        bus.bias  = 8'h22;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 300; i++) begin
            bus.in_valid = 1'b1;
            bus.v_bit    = 1'b1;
            bus.w        = 8'h40;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_sum_valid", 32'(bus.sum_valid), 32'd0);
        chk("midrst_sum", 32'(bus.sum), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);

        for (int i = 0; i < N_IN; i++) begin
            v_arr[i] = 1'($urandom);
            w_arr[i] = BITN'($urandom_range(0, 7)) - 8'd3;
        end
        do_run("after_rst", 8'hE8, 1'b0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hidden_sum_acc.md
Name: hidden_sum_acc

Overview:
Upstream neighbour of the sigmoid stage. It computes one hidden unit's pre-activation: bias plus the sum over N_IN visible units of v_i*w_i. Inputs are serial: one visible bit and one signed Q4.4 weight per accepted beat. The accumulator is wide internally, and the result is saturated to the SUM_BITN-wide signed Q8.4 word that the sigmoid stage consumes.

Parameters:
BITN, 8, weight/bias width, signed Q4.4
SUM_BITN, 12, output sum width, signed Q8.4 (matches sigmoid input width)
N_IN, 784, number of visible units per accumulation
CNT_BITN, 10, beat counter width, must hold N_IN-1
ACC_BITN, 20, internal accumulator width, must hold N_IN*2^(BITN-1)+bias without overflow

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  synchronous, active-high reset
start  in  1  begin an accumulation; honoured only in IDLE
bias  in  BITN  signed Q4.4 bias; sampled on the accepted start cycle
in_valid  in  1  v_bit/w beat valid
in_ready  out  1  block accepts a beat
v_bit  in  1  visible unit state (0/1)
w  in  BITN  signed Q4.4 weight paired with v_bit
sum_valid  out  1  sum holds a completed result
sum_ready  in  1  downstream accepts sum
sum  out  SUM_BITN  saturated signed Q8.4 pre-activation
sat_flag  out  1  the last result was clamped; valid with sum_valid
busy  out  1  block is not in IDLE

Behaviour:
- Reset: on rst high at a clock edge, the FSM goes to IDLE, with acc=0, cnt=0, sum=0, sum_valid=0, sat_flag=0, in_ready=0 and busy=0. A reset in the middle of an operation discards any partial accumulation.
- States and transitions:
  - IDLE: in_ready=0, busy=0. If start=1, then acc <= sign-extended bias, cnt <= 0, and the next state is ACCUM.
  - ACCUM: in_ready=1, busy=1.
    - A beat is accepted when in_valid&&in_ready.
    - On a beat: acc <= acc + (v_bit ? sext(w) : 0), and cnt <= cnt+1.
    - If the beat is accepted while cnt==N_IN-1: register sum=sat(acc_next), register sat_flag, set cnt <= 0 and go to HOLD.
    - If in_valid=0, nothing changes; there is no timeout.
  - HOLD: in_ready=0, sum_valid=1, busy=1. sum and sat_flag are held stable. If sum_ready=1, then sum_valid drops next cycle and the state returns to IDLE.
- Output registers: sum and sat_flag keep their last values after leaving HOLD, until the next completion or reset.
- Latency: sum_valid rises on the clock edge that accepts the N_IN-th beat. A zero-gap stream takes N_IN+1 cycles from start to sum_valid.
- start outside IDLE is ignored. start in the same cycle as the HOLD handshake is also ignored, so a back-to-back start must come at least one cycle after leaving HOLD.
- Arithmetic: two's complement throughout.
  - Bias and weights are sign-extended to ACC_BITN. The binary point is unchanged (Q.4), so no shifts are applied.
  - sat() clamps to [-2^(SUM_BITN-1), 2^(SUM_BITN-1)-1], i.e. 0x800..0x7FF.
  - sat_flag=1 if and only if clamping occurred.
  - The internal acc never wraps for legal parameters.
- v_bit=0 beats still count toward N_IN.
- The block generates no X on any output after reset.

Test Plan:
- start with bias=0x10, then 784 beats with v_bit=0 and random w -> sum=0x010, sat_flag=0, sum_valid rising exactly 785 cycles after start (zero-gap stream).
- bias=0x00, 784 beats with v_bit=1 and w=0x7F (784*127=99568) -> sum=0x7FF, sat_flag=1. Same with w=0x80 -> sum=0x800, sat_flag=1.
- bias=0xF0 (-1.0), v_bit alternating 1/0, w=0x01 -> 392-16=376 -> sum=0x178, sat_flag=0.
- Backpressure:
  - in_valid toggling randomly with 50% gaps -> same result as the zero-gap stream, and cnt advances only on accepted beats.
  - sum_ready held low 10 cycles in HOLD -> sum_valid=1 and sum stable throughout, and in_ready=0.
- rst asserted after 300 beats -> next cycle busy=0, sum_valid=0, sum=0. A fresh start then gives the correct result for a new full stream.
- start pulsed during ACCUM and during HOLD -> ignored: no re-init of acc, and the result matches a run without the extra pulse.
